rdma_hdr_arbiter: RTL and testbench

- Shares the single RDMAP header-generation input (`infoValid`/`rdmaControl`/`rdmaWR`) between four requesters: SEND, RCV, REQ and ACK.
- ACK has priority, but is throttled by buffer-register pool fullness and an ACK spacing rule; the other three requesters are served round-robin.
- Grants are limited by DDP header credits, so the downstream header path never overflows.
- Sits between the RDMA operation sources and the header generator, and provides a drain handshake for quiescing the header path.

---
 rtl/rdma_pkg.sv | 42 ++++
 rtl/rdma_rr_pick3.sv | 34 +++
 rtl/rdma_hdr_arbiter.sv | 143 ++++++++++++++
 tb/tb_rdma_hdr_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rdma_pkg.sv
// Shared types and constants for the RDMAP header arbiter: slot indices,
// opcodes and the drain FSM encoding.
package rdma_pkg;

    localparam int NUM_SLOTS = 4;
    localparam int CTL_W     = 16;
    localparam int WR_W      = 48;

    typedef logic [3:0] opcode_t;

    localparam opcode_t OP_SEND = 4'b0000;
    localparam opcode_t OP_RCV  = 4'b0001;
    localparam opcode_t OP_REQ  = 4'b0011;
    localparam opcode_t OP_ACK  = 4'b0111;

    typedef logic [1:0] slot_t;

    localparam slot_t SLOT_SEND = 2'd0;
    localparam slot_t SLOT_RCV  = 2'd1;
    localparam slot_t SLOT_REQ  = 2'd2;
    localparam slot_t SLOT_ACK  = 2'd3;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DRAIN   = 2'd1,
        DRAINED = 2'd2
    } arb_state_t;

    // Round-robin start point after serving one of the three rotating slots.
    function automatic slot_t rr_after(input slot_t s);
        return (s == SLOT_REQ) ? SLOT_SEND : slot_t'(s + 2'd1);
    endfunction

    function automatic slot_t onehot3_to_idx(input logic [2:0] oh);
        slot_t idx;
        idx = SLOT_SEND;
        if (oh[1]) idx = SLOT_RCV;
        if (oh[2]) idx = SLOT_REQ;
        return idx;
    endfunction

endpackage

// File: rtl/rdma_rr_pick3.sv
// Combinational round-robin picker over SEND/RCV/REQ; ptr names the slot
// searched first, the others follow in ascending order with wrap.
module rdma_rr_pick3
    import rdma_pkg::*;
(
    input  logic [2:0] req,
    input  slot_t      ptr,
    output logic [2:0] gnt
);

    always_comb begin
        // NOTE: every combinational output gets a default first so that no
        // path through the block leaves it unassigned and infers a latch.
        gnt = 3'b000;
        case (ptr)
            SLOT_RCV: begin
                if      (req[1]) gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
                else if (req[0]) gnt = 3'b001;
            end
            SLOT_REQ: begin
                if      (req[2]) gnt = 3'b100;
                else if (req[0]) gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
            end
            default: begin
                if      (req[0]) gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
            end
        endcase
    end

endmodule

// File: rtl/rdma_hdr_arbiter.sv
// Shares the RDMAP header-generator input between SEND/RCV/REQ/ACK with ACK
// priority, DDP header credit flow control and a drain handshake.
module rdma_hdr_arbiter
    import rdma_pkg::*;
#(
    parameter int CREDIT_MAX = 8,
    parameter int CREDIT_W   = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_SLOTS-1:0]          reqValid,
    output logic [NUM_SLOTS-1:0]          reqReady,
    input  logic [NUM_SLOTS*CTL_W-1:0]    reqControl,
    input  logic [NUM_SLOTS*WR_W-1:0]     reqWR,
    input  logic                          poolFull,
    input  logic                          ddpCreditRet,
    input  logic                          drainReq,
    output logic                          infoValid,
    output logic [CTL_W-1:0]              rdmaControl,
    output logic [WR_W-1:0]               rdmaWR,
    output logic [1:0]                    grantId,
    output logic [CREDIT_W-1:0]           creditCnt,
    output logic                          drained,
    output logic                          creditErr
);

    localparam logic [CREDIT_W-1:0] CREDIT_FULL = CREDIT_W'(CREDIT_MAX);

    arb_state_t state, state_next;
    slot_t      rr_ptr;
    logic       ack_last;
    logic       grant_ok;
    logic       ack_elig;
    logic       grant_any;
    logic [2:0] rr_gnt;
    logic [3:0] grant;
    slot_t      grant_idx;

    logic [CTL_W-1:0] slot_ctl [NUM_SLOTS];
    logic [WR_W-1:0]  slot_wr  [NUM_SLOTS];

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        assign slot_ctl[g] = reqControl[CTL_W*g +: CTL_W];
        assign slot_wr[g]  = reqWR[WR_W*g +: WR_W];
    end

    rdma_rr_pick3 u_pick (
        .req (reqValid[2:0]),
        .ptr (rr_ptr),
        .gnt (rr_gnt)
    );

    always_ff @(posedge clock or negedge reset) begin
        // NOTE: sequential state is only ever assigned with <= so every flop
        // samples pre-edge values regardless of statement order.
        if (!reset) state <= RUN;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (drainReq) state_next = DRAIN;
            DRAIN: begin
                if (!drainReq)
                    state_next = RUN;
                else if (creditCnt == CREDIT_FULL && !infoValid)
                    state_next = DRAINED;
            end
            DRAINED: if (!drainReq) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // A level drainReq blocks grants already in RUN, so its rising cycle never grants.
    always_comb begin
        grant_ok = reset && (state == RUN) && !drainReq && (creditCnt != '0);
        drained  = (state == DRAINED);
    end

    // The gap flag covers the one-cycle lag of poolFull behind an ACK grant.
    assign ack_elig = reqValid[SLOT_ACK] && !poolFull && !ack_last;

    always_comb begin
        grant     = 4'b0000;
        grant_idx = SLOT_SEND;
        if (grant_ok) begin
            if (ack_elig) begin
                grant[SLOT_ACK] = 1'b1;
                grant_idx       = SLOT_ACK;
            end else if (rr_gnt != 3'b000) begin
                grant[2:0] = rr_gnt;
                grant_idx  = onehot3_to_idx(rr_gnt);
            end
        end
    end

    assign grant_any = |grant;
    assign reqReady  = grant;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            creditCnt <= CREDIT_FULL;
            creditErr <= 1'b0;
        end else begin
            if (ddpCreditRet && creditCnt == CREDIT_FULL)
                creditErr <= 1'b1;
            if (grant_any && !ddpCreditRet)
                creditCnt <= creditCnt - CREDIT_W'(1);
            else if (ddpCreditRet && !grant_any && creditCnt != CREDIT_FULL)
                creditCnt <= creditCnt + CREDIT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            infoValid   <= 1'b0;
            rdmaControl <= '0;
            rdmaWR      <= '0;
            grantId     <= SLOT_SEND;
            rr_ptr      <= SLOT_SEND;
            ack_last    <= 1'b0;
        end else begin
            infoValid <= grant_any;
            ack_last  <= grant[SLOT_ACK];
            if (grant_any) begin
                rdmaControl <= slot_ctl[grant_idx];
                rdmaWR      <= slot_wr[grant_idx];
                grantId     <= grant_idx;
            end
            if (grant_any && !grant[SLOT_ACK])
                rr_ptr <= rr_after(grant_idx);
        end
    end

    a_ready_onehot: assert property (@(posedge clock) disable iff (!reset)
        $onehot0(reqReady));
    a_ready_needs_valid: assert property (@(posedge clock) disable iff (!reset)
        (reqReady & ~reqValid) == 4'b0000);
    a_credit_bound: assert property (@(posedge clock) disable iff (!reset)
        creditCnt <= CREDIT_FULL);

endmodule

// File: tb/tb_rdma_hdr_arbiter.sv
// Self-checking bench for rdma_hdr_arbiter: directed table, corner-case
// sequences and randomized traffic against a behavioural model.
module tb_rdma_hdr_arbiter;

    localparam int CREDIT_MAX = 8;
    localparam int CREDIT_W   = 4;
    localparam int M_RUN = 0, M_DRAIN = 1, M_DRAINED = 2;

    logic                clock = 1'b0;
    logic                reset = 1'b0;
    logic [3:0]          reqValid = '0;
    logic [3:0]          reqReady;
    logic [63:0]         reqControl = '0;
    logic [191:0]        reqWR = '0;
    logic                poolFull = 1'b0;
    logic                ddpCreditRet = 1'b0;
    logic                drainReq = 1'b0;
    logic                infoValid;
    logic [15:0]         rdmaControl;
    logic [47:0]         rdmaWR;
    logic [1:0]          grantId;
    logic [CREDIT_W-1:0] creditCnt;
    logic                drained;
    logic                creditErr;

    rdma_hdr_arbiter #(.CREDIT_MAX(CREDIT_MAX), .CREDIT_W(CREDIT_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .reqValid     (reqValid),
        .reqReady     (reqReady),
        .reqControl   (reqControl),
        .reqWR        (reqWR),
        .poolFull     (poolFull),
        .ddpCreditRet (ddpCreditRet),
        .drainReq     (drainReq),
        .infoValid    (infoValid),
        .rdmaControl  (rdmaControl),
        .rdmaWR       (rdmaWR),
        .grantId      (grantId),
        .creditCnt    (creditCnt),
        .drained      (drained),
        .creditErr    (creditErr)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] ctl [4];
    logic [47:0] wr  [4];
    logic [3:0]  last_ready;

    // Reference model state
    int          m_state, m_credit, m_rr, m_gid;
    bit          m_ack_last, m_err, m_iv;
    logic [15:0] m_ctl;
    logic [47:0] m_wr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_state = M_RUN; m_credit = CREDIT_MAX; m_rr = 0; m_gid = 0;
        m_ack_last = 0; m_err = 0; m_iv = 0; m_ctl = '0; m_wr = '0;
    endfunction

    // Which slot the rules grant this cycle, -1 for none.
    function automatic int model_pick(input logic [3:0] v, input bit pool, input bit drn);
        if (m_state != M_RUN || drn || m_credit == 0) return -1;
        if (v[3] && !pool && !m_ack_last) return 3;
        for (int k = 0; k < 3; k++) begin
            int s = (m_rr + k) % 3;
            if (v[s]) return s;
        end
        return -1;
    endfunction

    function automatic void model_update(input int g, input bit ret, input bit drn);
        int ns = m_state;
        if (m_state == M_RUN) begin
            if (drn) ns = M_DRAIN;
        end else if (!drn) begin
            ns = M_RUN;
        end else if (m_state == M_DRAIN && m_credit == CREDIT_MAX && !m_iv) begin
            ns = M_DRAINED;
        end
        if (ret && m_credit == CREDIT_MAX) m_err = 1;
        if (g >= 0 && !ret) m_credit--;
        else if (g < 0 && ret && m_credit < CREDIT_MAX) m_credit++;
        m_iv = (g >= 0);
        if (g >= 0) begin
            m_ctl = ctl[g]; m_wr = wr[g]; m_gid = g;
        end
        m_ack_last = (g == 3);
        if (g >= 0 && g < 3) m_rr = (g + 1) % 3;
        m_state = ns;
    endfunction

    // One clock: drive at negedge, check reqReady, check registers after posedge.
    task automatic cycle(input logic [3:0] v, input bit pool, input bit ret, input bit drn);
        int g;
        logic [3:0] exp_ready;
        for (int i = 0; i < 4; i++) begin
            ctl[i] = 16'($urandom);
            wr[i]  = {16'($urandom), $urandom};
            reqControl[16*i +: 16] = ctl[i];
            reqWR[48*i +: 48]      = wr[i];
        end
        reqValid = v; poolFull = pool; ddpCreditRet = ret; drainReq = drn;
        g = model_pick(v, pool, drn);
        exp_ready = (g >= 0) ? 4'(1 << g) : 4'b0000;
        #1;
        last_ready = reqReady;
        check("reqReady", reqReady, exp_ready);
        @(posedge clock);
        model_update(g, ret, drn);
        #1;
        check("infoValid", infoValid, m_iv);
        check("rdmaControl", rdmaControl, m_ctl);
        check("rdmaWR", rdmaWR, m_wr);
        check("grantId", grantId, m_gid);
        check("creditCnt", creditCnt, m_credit);
        check("drained", drained, m_state == M_DRAINED);
        check("creditErr", creditErr, m_err);
        @(negedge clock);
    endtask

    task automatic reset_dut();
        reqValid = '0; poolFull = 0; ddpCreditRet = 0; drainReq = 0;
        @(negedge clock);
        reset = 0;
        repeat (2) @(negedge clock);
        model_reset();
        reset = 1;
    endtask

    typedef struct {
        bit         rst;
        logic [3:0] v;
        bit         pool;
        bit         ret;
        logic [3:0] ready;
        int         credit;
        bit         iv;
    } vec_t;

    vec_t tbl[$];
    bit   drn_lvl;

    initial begin
        // Directed vectors: round-robin, ACK spacing, pool blocking.
        tbl.push_back('{1, 4'b0111, 0, 0, 4'b0001, 7, 1});
        tbl.push_back('{0, 4'b0111, 0, 0, 4'b0010, 6, 1});
        tbl.push_back('{0, 4'b0111, 0, 0, 4'b0100, 5, 1});
        tbl.push_back('{0, 4'b0111, 0, 0, 4'b0001, 4, 1});
        tbl.push_back('{0, 4'b0111, 0, 0, 4'b0010, 3, 1});
        tbl.push_back('{0, 4'b0111, 0, 0, 4'b0100, 2, 1});
        tbl.push_back('{1, 4'b1001, 0, 0, 4'b1000, 7, 1});
        tbl.push_back('{0, 4'b1001, 0, 0, 4'b0001, 6, 1});
        tbl.push_back('{0, 4'b1001, 0, 0, 4'b1000, 5, 1});
        tbl.push_back('{0, 4'b1001, 0, 0, 4'b0001, 4, 1});
        tbl.push_back('{0, 4'b1000, 1, 0, 4'b0000, 4, 0});
        tbl.push_back('{0, 4'b1000, 0, 0, 4'b1000, 3, 1});
        tbl.push_back('{0, 4'b1000, 0, 0, 4'b0000, 3, 0});
        tbl.push_back('{0, 4'b0000, 0, 1, 4'b0000, 4, 0});

        reset_dut();
        check("rst_infoValid", infoValid, 0);
        check("rst_creditCnt", creditCnt, CREDIT_MAX);
        check("rst_drained", drained, 0);
        check("rst_creditErr", creditErr, 0);
        check("rst_grantId", grantId, 0);

        foreach (tbl[i]) begin
            if (tbl[i].rst) reset_dut();
            cycle(tbl[i].v, tbl[i].pool, tbl[i].ret, 0);
            check($sformatf("tbl%0d_ready", i), last_ready, tbl[i].ready);
            check($sformatf("tbl%0d_credit", i), creditCnt, tbl[i].credit);
            check($sformatf("tbl%0d_iv", i), infoValid, tbl[i].iv);
        end

        // Credit exhaustion, return at zero, over-return error.
        reset_dut();
        repeat (8) cycle(4'b0001, 0, 0, 0);
        check("exhaust_credit", creditCnt, 0);
        cycle(4'b0001, 0, 0, 0);
        check("exhaust_noready", last_ready, 4'b0000);
        cycle(4'b0001, 0, 1, 0);
        check("ret_at_zero_noready", last_ready, 4'b0000);
        check("ret_at_zero_credit", creditCnt, 1);
        cycle(4'b0001, 0, 0, 0);
        check("ret_then_grant", last_ready, 4'b0001);
        check("ret_then_grant_credit", creditCnt, 0);
        repeat (8) cycle(4'b0000, 0, 1, 0);
        check("refill_credit", creditCnt, CREDIT_MAX);
        check("refill_noerr", creditErr, 0);
        cycle(4'b0000, 0, 1, 0);
        check("overret_err", creditErr, 1);
        check("overret_credit", creditCnt, CREDIT_MAX);
        cycle(4'b0000, 0, 0, 0);
        check("err_sticky", creditErr, 1);

        // Drain with three credits outstanding.
        reset_dut();
        repeat (3) cycle(4'b0001, 0, 0, 0);
        check("pre_drain_credit", creditCnt, 5);
        cycle(4'b0001, 0, 0, 1);
        check("drain_rise_suppress", last_ready, 4'b0000);
        repeat (3) begin
            cycle(4'b0001, 0, 1, 1);
            check("drain_noready", last_ready, 4'b0000);
            check("drain_not_done", drained, 0);
        end
        check("drain_full_credit", creditCnt, CREDIT_MAX);
        cycle(4'b0001, 0, 0, 1);
        check("drained_high", drained, 1);
        cycle(4'b0001, 0, 0, 1);
        check("drained_stays", drained, 1);
        cycle(4'b0001, 0, 0, 0);
        check("undrain_noready", last_ready, 4'b0000);
        check("undrain_low", drained, 0);
        cycle(4'b0001, 0, 0, 0);
        check("resume_grant", last_ready, 4'b0001);

        // Asynchronous reset mid-stream.
        reset_dut();
        repeat (5) cycle(4'b0111, 0, 0, 0);
        check("mid_credit", creditCnt, 3);
        reset = 0;
        #1;
        check("midrst_infoValid", infoValid, 0);
        check("midrst_control", rdmaControl, 0);
        check("midrst_wr", rdmaWR, 0);
        check("midrst_grantId", grantId, 0);
        check("midrst_credit", creditCnt, CREDIT_MAX);
        check("midrst_ready", reqReady, 4'b0000);
        check("midrst_drained", drained, 0);
        check("midrst_err", creditErr, 0);
        model_reset();
        reqValid = '0;
        @(negedge clock);
        reset = 1;
        cycle(4'b0111, 0, 0, 0);
        check("post_rst_first", last_ready, 4'b0001);

        // Randomized traffic against the model.
        reset_dut();
        drn_lvl = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(24) == 0) drn_lvl = !drn_lvl;
            cycle(4'($urandom), $urandom_range(99) < 25, $urandom_range(99) < 35, drn_lvl);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
